// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: the buffered request record and the arbiter states.
package wb_arbiter_pkg;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_req_t;

    typedef enum logic [0:0] {
        PIPE_PRI  = 1'b0,
        MDU_FORCE = 1'b1
    } wb_arb_state_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Power-of-two result buffer for MDU writebacks; head is presented combinationally.
module wb_result_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  wb_req_t i_data,
    input  logic    i_pop,
    output wb_req_t o_data,
    output logic    o_full,
    output logic    o_empty
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    wb_req_t         r_mem [FIFO_DEPTH];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == CntW'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only readable behind a valid count.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: pipeline has priority, buffered MDU results are force-granted
// after STARVE_LIMIT waiting cycles. Define WB_ARB_STATS_EN to enable the conflict_cnt counter.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic        pipe_reg_write,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    output logic        pipe_stall,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [15:0] conflict_cnt
);

    localparam int unsigned WaitW = $clog2(STARVE_LIMIT + 2);

    wb_arb_state_e    r_state;
    wb_arb_state_e    w_state_d;
    logic [WaitW-1:0] r_wait;
    logic [WaitW-1:0] w_wait_d;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    wb_req_t          w_head;
    wb_req_t          w_mdu_in;
    wb_req_t          w_grant_req;
    logic             w_push;
    logic             w_pipe_req;
    logic             w_mdu_req;
    logic             w_grant_pipe;
    logic             w_grant_fifo;
    logic             w_grant_any;
    logic             r_rf_we;
    logic [4:0]       r_rf_waddr;
    logic [31:0]      r_rf_wdata;

    assign w_mdu_in   = '{rd: mdu_rd, data: mdu_data};
    assign mdu_ready  = !w_fifo_full;
    assign w_push     = mdu_valid && mdu_ready;
    assign w_pipe_req = pipe_valid && pipe_reg_write;
    assign w_mdu_req  = !w_fifo_empty;

    wb_result_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_mdu_in),
        .i_pop   (w_grant_fifo),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_comb begin
        w_grant_pipe = 1'b0;
        w_grant_fifo = 1'b0;
        w_state_d    = r_state;
        case (r_state)
            PIPE_PRI: begin
                if (w_pipe_req)     w_grant_pipe = 1'b1;
                else if (w_mdu_req) w_grant_fifo = 1'b1;
            end
            MDU_FORCE: begin
                w_grant_fifo = w_mdu_req;
                w_state_d    = PIPE_PRI;
            end
            default: w_state_d = PIPE_PRI;
        endcase

        if (!w_mdu_req || w_grant_fifo) w_wait_d = '0;
        else                            w_wait_d = r_wait + 1'b1;

        // Enter MDU_FORCE on the cycle the counter reaches the limit so the next one is forced.
        if (r_state == PIPE_PRI && w_mdu_req && !w_grant_fifo &&
            32'(w_wait_d) >= STARVE_LIMIT) begin
            w_state_d = MDU_FORCE;
        end
    end

    assign w_grant_any = w_grant_pipe || w_grant_fifo;
    assign w_grant_req = w_grant_fifo ? w_head : '{rd: pipe_rd, data: pipe_data};
    assign pipe_stall  = (r_state == MDU_FORCE) && w_pipe_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= PIPE_PRI;
            r_wait     <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_state <= w_state_d;
            r_wait  <= w_wait_d;
            // Grants to x0 are consumed without a register-file write.
            r_rf_we <= w_grant_any && (w_grant_req.rd != 5'd0);
            if (w_grant_any) begin
                r_rf_waddr <= w_grant_req.rd;
                r_rf_wdata <= w_grant_req.data;
            end
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;

`ifdef WB_ARB_STATS_EN
    logic [15:0] r_conflict_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if (pipe_stall && r_conflict_cnt != 16'hFFFF) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`else
    assign conflict_cnt = '0;
`endif

endmodule
